pfa_crt_agu: RTL
================

Name: pfa_crt_agu

Overview:
- Output-side address generator for the prime-factor-algorithm (PFA) FFT.
- It is the counterpart of the input-side n1/n2 index-mapping AGU. That AGU walks the (n1,n2) input counters; this block walks the output indices (k1,k2) and converts them to the linear CRT output address k = (k1*A + k2*B) mod N.
- Results are read out of the PFA buffer in natural order.
- It uses incremental modular adds only, with no multipliers, and has a start/valid-ready/done handshake toward the read port.

Parameters:
W, 12, width of N1, N2, N, A, B, k1, k2 and the address (N <= 2^W-1).

Ports:
clk  in  1  clock.
rst_n  in  1  synchronous active-high reset; despite its name, 1 = reset.
start  in  1  one-cycle pulse that begins a pass; accepted only in IDLE.
N1  in  W  inner factor (>=1); sampled on accepted start.
N2  in  W  outer factor (>=1); sampled on accepted start.
N  in  W  transform length = N1*N2; sampled on accepted start.
A  in  W  CRT coefficient N2*(N2^-1 mod N1), < N; sampled on accepted start.
B  in  W  CRT coefficient N1*(N1^-1 mod N2), < N; sampled on accepted start.
out_ready  in  1  consumer accepts the current address.
addr_valid  out  1  k_addr/k1_out/k2_out are valid.
k_addr  out  W  CRT linear address.
k1_out  out  W  current inner index.
k2_out  out  W  current outer index.
busy  out  1  high in RUN.
done  out  1  one-cycle pulse after the last address is accepted.

Behaviour:
- Reset (synchronous, rst_n=1 at a clk edge):
  - state=IDLE.
  - k1, k2, k_addr and the row base register are cleared to 0.
  - addr_valid, busy and done are cleared to 0.
  - Reset mid-pass aborts immediately, with no done pulse.
- State machine: IDLE -> RUN on start. RUN -> DONE on the last handshake. DONE -> IDLE unconditionally after 1 cycle.
- IDLE, start=1:
  - Latch N1, N2, N, A and B.
  - k1=k2=0, base=0, k_addr=0.
  - addr_valid=1 and busy=1 from the next cycle. Latency from start to first valid is 1 cycle.
- start outside IDLE is ignored. This includes RUN and the DONE cycle. Latched parameters never change during a pass.
- RUN: a handshake occurs when addr_valid & out_ready. With no handshake, all outputs hold stable (backpressure).
- Handshake, k1 != N1-1:
  - k1+1.
  - k_addr = k_addr+A; subtract N if the sum >= N.
  - Compute in W+1 bits.
- Handshake, k1 == N1-1, k2 != N2-1:
  - k1=0, k2+1.
  - base = base+B, reduced mod N by a single conditional subtract.
  - k_addr = the new base, in the same cycle.
- Handshake, k1 == N1-1 and k2 == N2-1:
  - Next state is DONE.
  - addr_valid=0, busy=0, done=1 for exactly one cycle.
  - Counters and k_addr return to 0.
- A pass always produces exactly N1*N2 addresses.
- If A and B are correct CRT coefficients, the sequence is a permutation of 0..N-1. The block does not check this.
- N1=1: every handshake takes the row-advance branch, so the sequence is base values 0, B, 2B mod N, ...
- N1=N2=1: a single address 0, then done.
- Outputs are registered. There is no combinational path from out_ready to addr_valid or k_addr.

Test Plan:
- N1=3, N2=4, N=12, A=4, B=9, out_ready=1 constantly, start pulse:
  - k_addr is 0,4,8,9,1,5,6,10,2,3,7,11 on consecutive cycles, beginning 1 cycle after start.
  - k1/k2 match row-major order with k1 inner.
  - done pulses 1 cycle after the 12th address; busy is high for exactly 12 cycles.
- N1=2, N2=3, N=6, A=3, B=4, out_ready toggling 1,0,1,0:
  - Accepted sequence is 0,3,4,1,2,5.
  - Outputs are stable in cycles where out_ready=0.
  - done comes after the 6th acceptance.
- start re-pulsed during RUN and in the DONE cycle (config from test 1):
  - Sequence is unaffected and there is a single done.
  - A start pulse on the cycle after DONE begins a new identical pass.
- rst_n=1 asserted after the 5th address of test 1:
  - Next cycle addr_valid=0, busy=0, done=0, k_addr=0, with no done pulse.
  - A later start produces the full sequence from 0.
- N1=1, N2=4, N=4, A=0, B=1: sequence 0,1,2,3, then done.
- N1=N2=1, N=1: one address 0 with k1=k2=0, then done on the following cycle.

Source files
------------

// File: rtl/pfa_crt_agu.sv
// Output-side PFA FFT address generator: walks (k1,k2) in natural order and emits the
// CRT linear address k = (k1*A + k2*B) mod N using only incremental modular adds.
module pfa_crt_agu #(
  parameter int unsigned W = 12
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_start,
  input  logic [W-1:0] i_n1,
  input  logic [W-1:0] i_n2,
  input  logic [W-1:0] i_n,
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  input  logic         i_out_ready,
  output logic         o_addr_valid,
  output logic [W-1:0] o_k_addr,
  output logic [W-1:0] o_k1_out,
  output logic [W-1:0] o_k2_out,
  output logic         o_busy,
  output logic         o_done
);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e       r_state;
  state_e       w_state_next;
  logic [W-1:0] r_n1, r_n2, r_n, r_a, r_b;
  logic [W-1:0] r_k1, r_k2, r_base, r_addr;

  logic         w_hs;
  logic         w_k1_last;
  logic         w_k2_last;
  logic [W:0]   w_sum_a, w_sub_a;
  logic [W:0]   w_sum_b, w_sub_b;
  logic [W-1:0] w_addr_step;
  logic [W-1:0] w_base_step;

  assign w_hs      = (r_state == StRun) && i_out_ready;
  assign w_k1_last = (r_k1 == r_n1 - W'(1));
  assign w_k2_last = (r_k2 == r_n2 - W'(1));

  // Operands are < N, so one conditional subtract keeps the sum reduced mod N.
  assign w_sum_a     = {1'b0, r_addr} + {1'b0, r_a};
  assign w_sub_a     = w_sum_a - {1'b0, r_n};
  assign w_addr_step = (w_sum_a >= {1'b0, r_n}) ? w_sub_a[W-1:0] : w_sum_a[W-1:0];
  assign w_sum_b     = {1'b0, r_base} + {1'b0, r_b};
  assign w_sub_b     = w_sum_b - {1'b0, r_n};
  assign w_base_step = (w_sum_b >= {1'b0, r_n}) ? w_sub_b[W-1:0] : w_sum_b[W-1:0];

  always_ff @(posedge i_clk) begin
    if (i_rst_n) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle:  if (i_start) w_state_next = StRun;
      StRun:   if (w_hs && w_k1_last && w_k2_last) w_state_next = StDone;
      StDone:  w_state_next = StIdle;
      default: w_state_next = StIdle;
    endcase
  end

  always_comb begin
    o_addr_valid = (r_state == StRun);
    o_busy       = (r_state == StRun);
    o_done       = (r_state == StDone);
    o_k_addr     = r_addr;
    o_k1_out     = r_k1;
    o_k2_out     = r_k2;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst_n) begin
      r_n1   <= '0;
      r_n2   <= '0;
      r_n    <= '0;
      r_a    <= '0;
      r_b    <= '0;
      r_k1   <= '0;
      r_k2   <= '0;
      r_base <= '0;
      r_addr <= '0;
    end else if ((r_state == StIdle) && i_start) begin
      r_n1   <= i_n1;
      r_n2   <= i_n2;
      r_n    <= i_n;
      r_a    <= i_a;
      r_b    <= i_b;
      r_k1   <= '0;
      r_k2   <= '0;
      r_base <= '0;
      r_addr <= '0;
    end else if (w_hs) begin
      if (!w_k1_last) begin
        r_k1   <= r_k1 + W'(1);
        r_addr <= w_addr_step;
      end else if (!w_k2_last) begin
        r_k1   <= '0;
        r_k2   <= r_k2 + W'(1);
        r_base <= w_base_step;
        r_addr <= w_base_step;
      end else begin
        r_k1   <= '0;
        r_k2   <= '0;
        r_base <= '0;
        r_addr <= '0;
      end
    end
  end

endmodule
